vga_frame_writer: RTL

- CPU-side writer into the 32K x 16 video RAM that the VGA display path reads, packing two 8-bit rrr_ggg_bb pixels per word.
- Accepts pixel-write commands (x, y, color) via valid/ready and buffers them in a small FIFO.
- Converts coordinates to word address plus byte enable and issues writes on a stallable memory write port.
- Optional hardware fill sweeps the whole frame with a single colour.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_cmd_fifo.sv | 57 +++++
 rtl/vga_frame_writer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and frame geometry for the VGA frame writer.
// Fill feature is compiled in with VGAW_FILL_EN.
package vga_pkg;

    localparam int H_PIXELS       = 320;
    localparam int V_LINES        = 200;
    localparam int WORDS_PER_LINE = 160;
    localparam int VRAM_WORDS     = 32000;

    typedef logic [7:0] color_t;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        color_t     color;
    } pix_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2
    } state_t;

    // y*160 + x/2 without a multiplier
    function automatic logic [14:0] pix_addr(input logic [8:0] x_word, input logic [8:0] y);
        logic [16:0] sum;
        sum = ({8'd0, y} << 7) + ({8'd0, y} << 5) + {8'd0, x_word};
        return sum[14:0];
    endfunction

endpackage

// File: rtl/vga_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so pointers wrap naturally.
module vga_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            store[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_frame_writer.sv
// Buffers CPU pixel writes and issues byte-enabled word writes into video RAM.
// Define VGAW_FILL_EN to add the whole-frame hardware fill.
module vga_frame_writer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int H_PIXELS       = vga_pkg::H_PIXELS,
    parameter int V_LINES        = vga_pkg::V_LINES,
    parameter int WORDS_PER_LINE = vga_pkg::WORDS_PER_LINE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x,
    input  logic [8:0]  cmd_y,
    input  logic [7:0]  cmd_color,
    input  logic        fill_start,
    input  logic [7:0]  fill_color,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_data,
    output logic [1:0]  mem_be,
    output logic        busy,
    output logic        err_oob,
    input  logic        err_clr
);

    import vga_pkg::*;

    localparam logic [9:0]  X_LIM     = 10'(H_PIXELS);
    localparam logic [8:0]  Y_LIM     = 9'(V_LINES);
    localparam logic [14:0] LAST_ADDR = 15'(V_LINES * WORDS_PER_LINE - 1);

    state_t      state;
    pix_cmd_t    head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        head_oob;
    logic [14:0] head_addr;

    vga_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(pix_cmd_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data ({cmd_x, cmd_y, cmd_color}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_oob  = (head.x >= X_LIM) || (head.y >= Y_LIM);
    assign head_addr = pix_addr(head.x[9:1], head.y);
    assign push      = cmd_valid && cmd_ready;
    // A new entry is taken whenever the write port is free or its current write is accepted
    assign pop       = !fifo_empty && ((state == IDLE) || (state == WRITE && mem_ready));

`ifdef VGAW_FILL_EN
    logic   fill_pending;
    color_t fill_c;

    assign cmd_ready = !fifo_full && (state != FILL) && !fill_pending;
    assign busy      = !fifo_empty || (state != IDLE) || fill_pending;

    always_ff @(posedge clk) begin
        if (fill_start && !fill_pending && state != FILL) begin
            fill_c <= fill_color;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{fill_start, fill_color, LAST_ADDR};
    assign cmd_ready  = !fifo_full;
    assign busy       = !fifo_empty || (state != IDLE);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_be   <= '0;
            err_oob  <= 1'b0;
`ifdef VGAW_FILL_EN
            fill_pending <= 1'b0;
`endif
        end else begin
            if (err_clr) begin
                err_oob <= 1'b0;
            end
            if (pop && head_oob) begin
                err_oob <= 1'b1;
            end
`ifdef VGAW_FILL_EN
            if (fill_start && !fill_pending && state != FILL) begin
                fill_pending <= 1'b1;
            end
`endif
            case (state)
                IDLE, WRITE: begin
                    if (state == IDLE || mem_ready) begin
                        if (!fifo_empty) begin
                            if (head_oob) begin
                                state  <= IDLE;
                                mem_we <= 1'b0;
                            end else begin
                                state    <= WRITE;
                                mem_we   <= 1'b1;
                                mem_addr <= head_addr;
                                mem_data <= {head.color, head.color};
                                mem_be   <= head.x[0] ? 2'b01 : 2'b10;
                            end
                        end
`ifdef VGAW_FILL_EN
                        else if (state == IDLE && fill_pending) begin
                            state        <= FILL;
                            fill_pending <= 1'b0;
                            mem_we       <= 1'b1;
                            mem_addr     <= '0;
                            mem_data     <= {fill_c, fill_c};
                            mem_be       <= 2'b11;
                        end
`endif
                        else begin
                            state  <= IDLE;
                            mem_we <= 1'b0;
                        end
                    end
                end
`ifdef VGAW_FILL_EN
                FILL: begin
                    if (mem_ready) begin
                        if (mem_addr == LAST_ADDR) begin
                            state  <= IDLE;
                            mem_we <= 1'b0;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
